pmp_dmp_checker: RTL
====================

Name: pmp_dmp_checker

Overview:
- Pipelined, multi-port PMP+DMP access checker.
- Owns the current-domain (curdom) register and serialises domain switches against in-flight checks.
- Each of N_PORTS request channels carries a valid/ready request; the registered allow/deny response comes back one cycle later.
- Sits between the LSU/fetch request paths and the memory interface; wraps the existing combinational pmp checker, one instance per port.

Parameters:
- PLEN, 56, physical address width.
- PMP_LEN, 54, width of each pmpaddr entry.
- NR_ENTRIES, 16, number of PMP/DMP entries, 1..16.
- N_PORTS, 2, number of independent request channels, 1..4.
- CNT_W, 16, width of the per-port fault counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  N_PORTS  request valid per port
- req_ready_o  out  N_PORTS  request accepted per port
- req_addr_i  in  N_PORTS x PLEN  request physical address
- req_access_i  in  N_PORTS x riscv::pmp_access_t  access type (R/W/X)
- priv_lvl_i  in  riscv::priv_lvl_t  privilege level, sampled with each request
- resp_valid_o  out  N_PORTS  response valid
- resp_ready_i  in  N_PORTS  response consumed
- resp_allow_o  out  N_PORTS  1 = access permitted
- conf_addr_i  in  NR_ENTRIES x PMP_LEN  pmpaddr CSRs
- pmpconf_i  in  NR_ENTRIES x riscv::pmpcfg_t  pmpcfg CSRs
- dmpconf_i  in  NR_ENTRIES x riscv::dmpcfg_t  dmpcfg CSRs
- dsw_valid_i  in  1  domain-switch request
- dsw_dom_i  in  riscv::dmp_domain_t  target domain
- dsw_ready_o  out  1  switch committed (single-cycle pulse)
- curdom_o  out  riscv::dmp_domain_t  current domain
- fault_clr_i  in  1  synchronous clear of all fault counters
- fault_cnt_o  out  N_PORTS x CNT_W  saturating deny count per port

Behaviour:
- Reset values:
  - curdom = DOMI; FSM = RUN.
  - All stage-valid flags 0, so resp_valid_o = 0.
  - resp_allow_o = 0; dsw_ready_o = 0; fault_cnt_o = 0.
- Per-port stage: one register holding valid, addr, access and priv.
- Request handshake:
  - req_ready_o[p] = (state==RUN) & (!stage_valid[p] | resp_ready_i[p]).
  - A request is accepted when req_valid_i & req_ready_o are both 1; it loads the stage.
  - The stage clears on a response handshake with no new accept.
- Response:
  - resp_valid_o[p] = stage_valid[p].
  - resp_allow_o is combinational from the stage registers, the live CSR inputs and the curdom register. Latency is exactly 1 cycle when resp_ready_i=1.
  - resp_allow_o is forced to 0 whenever the stage is invalid.
  - While resp_ready_i=0 the response holds stable; CSRs must not change while any stage is valid (software guarantee, covered by assertion).
- Allow rule: pmp_ok & dmp_ok, both evaluated on the first matching entry.
  - pmp_ok: the standard pmp result.
  - dmp_ok = (curdom==DOMI) | (entry.domain==DOMI) | (entry.domain==curdom).
  - No matching entry: dmp_ok = 1.
- FSM states RUN, DRAIN, COMMIT:
  - RUN: dsw_valid_i=1 moves to DRAIN. req_ready_o deasserts from the next cycle; a request accepted in the same cycle still completes under the old domain.
  - DRAIN: no new accepts. When all stage_valid=0, go to COMMIT.
  - COMMIT: curdom <= dsw_dom_i, dsw_ready_o=1 for this cycle, then return to RUN.
  - dsw_valid_i must stay asserted until dsw_ready_o. Deassertion in DRAIN aborts back to RUN with curdom unchanged.
  - Switch to the same domain: still drains and commits, with a normal dsw_ready_o pulse.
- Fault counters:
  - Increment on a response handshake with resp_allow_o=0.
  - Saturate at 2^CNT_W-1.
  - fault_clr_i has priority over an increment in the same cycle.
- Reset asserted mid-operation: all in-flight requests are dropped, a pending switch is lost, curdom returns to DOMI.

Decomposition:
- riscv package additions:
  - dmp_domain_t with DOM0, DOM1, DOM2, DOMI.
  - dmpcfg_t.
  - a dsw_state_e enum.
  - a dmp_dom_ok() function implementing the DMP rule.
- Sub-module: the existing pmp checker, instantiated once per port. Its allow_o already includes the DMP term via curdom_i.
- This block adds only pipelining, the switch FSM and the counters.

Test Plan:
- Reset → curdom_o=DOMI, resp_valid_o=0, fault_cnt_o=0.
- Entry0 NAPOT 0x1800–0x1FFF, RWX, domain DOM1; curdom DOMI; port0 read 0x19BA → resp_valid_o 1 cycle later, allow=1.
- Switch to DOM0 (dsw_dom_i=DOM0) → dsw_ready_o pulses once and curdom_o=DOM0. A following read of 0x19BA → allow=0 and fault_cnt_o[0]=1. Retarget the entry to DOMI → allow=1.
- Port1 holds resp_ready_i=0 with an outstanding request while dsw_valid_i=1 → req_ready_o=0 on both ports and no dsw_ready_o. Release resp_ready_i → COMMIT on the next cycle; the held response used the old domain.
- Entry0 X-only; ports 0 and 1 issue simultaneous reads of 0x19BA for 3 cycles → allow=0 each cycle, both counters = 3. fault_clr_i together with a deny → counter = 0.
- CNT_W=4 with 20 denied requests → fault_cnt_o=15. Assert rst_ni low during DRAIN → FSM RUN, curdom=DOMI, no dsw_ready_o.

Source files
------------

// File: rtl/pmp_dmp_checker_pkg.sv
// Shared PMP/DMP types, switch FSM states and the domain rule.
// Imported by the checker datapath and the pipelined top.
package pmp_dmp_checker_pkg;

    typedef enum logic [2:0] {
        ACCESS_NONE  = 3'b000,
        ACCESS_READ  = 3'b001,
        ACCESS_WRITE = 3'b010,
        ACCESS_EXEC  = 3'b100
    } pmp_access_t;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;

    typedef enum logic [1:0] {
        DOM0 = 2'b00,
        DOM1 = 2'b01,
        DOM2 = 2'b10,
        DOMI = 2'b11
    } dmp_domain_t;

    typedef struct packed {
        dmp_domain_t domain;
    } dmpcfg_t;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        COMMIT = 2'b10
    } dsw_state_e;

    // DOMI on either side is a wildcard; otherwise domains must match
    function automatic logic dmp_dom_ok(dmp_domain_t cur, dmp_domain_t ent);
        return (cur == DOMI) || (ent == DOMI) || (ent == cur);
    endfunction

endpackage

// File: rtl/pmp_dmp_checker_pmp.sv
// Combinational PMP checker with the DMP domain term folded in.
// The lowest-numbered matching entry decides the access.
module pmp_dmp_checker_pmp
    import pmp_dmp_checker_pkg::*;
#(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16
) (
    input  logic [PLEN-1:0]                       addr_i,
    input  pmp_access_t                           access_i,
    input  priv_lvl_t                             priv_lvl_i,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]    conf_addr_i,
    input  pmpcfg_t [NR_ENTRIES-1:0]              conf_i,
    input  dmpcfg_t [NR_ENTRIES-1:0]              dmpconf_i,
    input  dmp_domain_t                           curdom_i,
    output logic                                  allow_o
);

    logic [PMP_LEN-1:0]                    word_addr;
    logic [NR_ENTRIES-1:0][PMP_LEN-1:0]    base;
    logic [NR_ENTRIES-1:0][PMP_LEN-1:0]    napot_care;
    logic [NR_ENTRIES-1:0]                 match;
    logic [NR_ENTRIES-1:0]                 pmp_ok;
    logic [NR_ENTRIES-1:0]                 dmp_ok;
    logic                                  unused_bits;

    assign word_addr = addr_i[PMP_LEN+1:2];

    // TOR lower bound is the previous entry's address, zero for entry 0
    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_base
        if (i == 0) begin : g_first
            assign base[i] = '0;
        end else begin : g_rest
            assign base[i] = conf_addr_i[i-1];
        end
        assign napot_care[i] =
            ~(conf_addr_i[i] ^ (conf_addr_i[i] + PMP_LEN'(1)));
    end

    // per-entry address match and permission evaluation
    always_comb begin
        match       = '0;
        pmp_ok      = '0;
        dmp_ok      = '0;
        unused_bits = ^addr_i[1:0];
        for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            unused_bits = unused_bits ^ (^conf_i[i].reserved);
            case (conf_i[i].addr_mode)
                TOR:     match[i] = (word_addr >= base[i]) &&
                                    (word_addr < conf_addr_i[i]);
                NA4:     match[i] = (word_addr == conf_addr_i[i]);
                NAPOT:   match[i] = (((word_addr ^ conf_addr_i[i]) &
                                      napot_care[i]) == '0);
                default: match[i] = 1'b0;
            endcase
            pmp_ok[i] = ((3'(access_i) & 3'(conf_i[i].access_type)) ==
                         3'(access_i)) ||
                        ((priv_lvl_i == PRIV_LVL_M) && !conf_i[i].locked);
            dmp_ok[i] = dmp_dom_ok(curdom_i, dmpconf_i[i].domain);
        end
    end

    // scan downwards so the lowest matching index has the last word
    always_comb begin
        allow_o = (priv_lvl_i == PRIV_LVL_M);
        for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
            if (match[i]) begin
                allow_o = pmp_ok[i] & dmp_ok[i];
            end
        end
    end

endmodule

// File: rtl/pmp_dmp_checker.sv
// Pipelined multi-port PMP+DMP checker owning the current domain.
// Domain switches drain in-flight checks before committing.
module pmp_dmp_checker
    import pmp_dmp_checker_pkg::*;
#(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_PORTS-1:0]                  req_valid_i,
    output logic [N_PORTS-1:0]                  req_ready_o,
    input  logic [N_PORTS-1:0][PLEN-1:0]        req_addr_i,
    input  pmp_access_t [N_PORTS-1:0]           req_access_i,
    input  priv_lvl_t                           priv_lvl_i,
    output logic [N_PORTS-1:0]                  resp_valid_o,
    input  logic [N_PORTS-1:0]                  resp_ready_i,
    output logic [N_PORTS-1:0]                  resp_allow_o,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]  conf_addr_i,
    input  pmpcfg_t [NR_ENTRIES-1:0]            pmpconf_i,
    input  dmpcfg_t [NR_ENTRIES-1:0]            dmpconf_i,
    input  logic                                dsw_valid_i,
    input  dmp_domain_t                         dsw_dom_i,
    output logic                                dsw_ready_o,
    output dmp_domain_t                         curdom_o,
    input  logic                                fault_clr_i,
    output logic [N_PORTS-1:0][CNT_W-1:0]       fault_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dsw_state_e                     state;
    dmp_domain_t                    curdom;
    logic [N_PORTS-1:0]             stage_valid;
    logic [N_PORTS-1:0][PLEN-1:0]   stage_addr;
    pmp_access_t [N_PORTS-1:0]      stage_access;
    priv_lvl_t [N_PORTS-1:0]        stage_priv;
    logic [N_PORTS-1:0]             chk_allow;
    logic [N_PORTS-1:0]             accept;
    logic [N_PORTS-1:0]             resp_hs;

    assign curdom_o     = curdom;
    assign resp_valid_o = stage_valid;
    assign req_ready_o  = {N_PORTS{state == RUN}} &
                          (~stage_valid | resp_ready_i);
    assign accept       = req_valid_i & req_ready_o;
    assign resp_hs      = stage_valid & resp_ready_i;
    assign resp_allow_o = stage_valid & chk_allow;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        pmp_dmp_checker_pmp #(
            .PLEN       (PLEN),
            .PMP_LEN    (PMP_LEN),
            .NR_ENTRIES (NR_ENTRIES)
        ) u_pmp (
            .addr_i      (stage_addr[p]),
            .access_i    (stage_access[p]),
            .priv_lvl_i  (stage_priv[p]),
            .conf_addr_i (conf_addr_i),
            .conf_i      (pmpconf_i),
            .dmpconf_i   (dmpconf_i),
            .curdom_i    (curdom),
            .allow_o     (chk_allow[p])
        );
    end

    // request stage: load on accept, empty on a bare response handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_valid  <= '0;
            stage_addr   <= '0;
            stage_access <= {N_PORTS{ACCESS_NONE}};
            stage_priv   <= {N_PORTS{PRIV_LVL_M}};
        end else begin
            for (int p = 0; p < int'(N_PORTS); p++) begin
                if (accept[p]) begin
                    stage_valid[p]  <= 1'b1;
                    stage_addr[p]   <= req_addr_i[p];
                    stage_access[p] <= req_access_i[p];
                    stage_priv[p]   <= priv_lvl_i;
                end else if (resp_hs[p]) begin
                    stage_valid[p] <= 1'b0;
                end
            end
        end
    end

    // saturating deny counters, clear beats increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_cnt_o <= '0;
        end else begin
            for (int p = 0; p < int'(N_PORTS); p++) begin
                if (fault_clr_i) begin
                    fault_cnt_o[p] <= '0;
                end else if (resp_hs[p] && !resp_allow_o[p] &&
                             (fault_cnt_o[p] != CNT_MAX)) begin
                    fault_cnt_o[p] <= fault_cnt_o[p] + CNT_W'(1);
                end
            end
        end
    end

    // domain switch: stop accepts, drain stages, then commit curdom
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= RUN;
            curdom      <= DOMI;
            dsw_ready_o <= 1'b0;
        end else begin
            dsw_ready_o <= 1'b0;
            case (state)
                RUN: begin
                    if (dsw_valid_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!dsw_valid_i) begin
                        state <= RUN;
                    end else if (stage_valid == '0) begin
                        state       <= COMMIT;
                        dsw_ready_o <= 1'b1;
                    end
                end
                COMMIT: begin
                    curdom <= dsw_dom_i;
                    state  <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifndef SYNTHESIS
    // CSRs are frozen by software while any check is in flight
    csr_stable_a: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (|stage_valid) |-> $stable({conf_addr_i, pmpconf_i, dmpconf_i}));
`endif

endmodule
